output_unloader: RTL and testbench

Drains the Output Memory after the Bellman-Ford engine raises Finish and streams the shortest-path distances out over a valid/ready interface, one 16-bit word per node in address order. Sits directly downstream of the bellmanford core and shares the Output Memory read port with it once the core is idle. Also reports a negative-cycle abort and per-run summary counts (unreachable nodes, maximum finite distance).

---
 rtl/output_unloader_if.sv | 27 ++
 rtl/output_unloader.sv | 191 +++++++++++++++++++
 tb/tb_output_unloader.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_unloader_if.sv
// output_unloader_if: valid/ready distance stream leaving the output unloader.
// master drives the word and its flags, slave returns out_ready.
interface output_unloader_if #(
  parameter int DATA_W = 16
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_unreach;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    output out_unreach,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    input  out_unreach,
    output out_ready
  );
endinterface

// File: rtl/output_unloader.sv
// output_unloader: after the Bellman-Ford core raises Finish, reads the Output
// Memory in address order and streams one distance word per node over a
// valid/ready interface. A NegCycle rise aborts or pre-empts the stream and sets
// a sticky neg_flag. Per-run summary: unreachable count and largest finite distance.
// Optional feature: define OUTPUT_UNLOADER_CHECKSUM_EN to append a 16-bit
// wrapping-sum word after the last distance word (out_last moves onto it).
module output_unloader #(
  parameter int                ADDR_W  = 13,
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] UNREACH = '1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      Finish,
  input  logic                      NegCycle,
  input  logic [ADDR_W:0]           num_nodes,
  output logic [ADDR_W-1:0]         OMAR,
  input  logic [DATA_W-1:0]         OMDR,
  output_unloader_if.master         strm,
  output logic                      busy,
  output logic                      done,
  output logic                      neg_flag,
  output logic [ADDR_W:0]           unreach_cnt,
  output logic [DATA_W-1:0]         max_dist
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    NEG
  } state_t;

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] NMAX    = {1'b1, {ADDR_W{1'b0}}};

  state_t          state;
  logic            fin_d1, fin_d2;
  logic            neg_d1, neg_d2;
  logic            fin_rise, neg_rise;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] last_idx;
  logic [ADDR_W:0] n_last;
  logic            load;
  logic            at_last;
  logic            word_unreach;
`ifdef OUTPUT_UNLOADER_CHECKSUM_EN
  logic [DATA_W-1:0] cks;
  logic              cks_pend;
`endif

  assign fin_rise     = fin_d1 & ~fin_d2;
  assign neg_rise     = neg_d1 & ~neg_d2;
  assign load         = !strm.out_valid || strm.out_ready;
  assign at_last      = (rd_ptr == last_idx);
  assign word_unreach = (OMDR == UNREACH);

  // Last node index for the requested count: 0 behaves as 1, oversize clamps to full memory.
  always_comb begin
    n_last = num_nodes - PTR_ONE;
    if (num_nodes == '0) begin
      n_last = '0;
    end else if (num_nodes > NMAX) begin
      n_last = NMAX - PTR_ONE;
    end
  end

  // Read address follows the pointer only while streaming so the core keeps the port otherwise.
  always_comb begin
    OMAR = '0;
    if (state == STREAM) begin
      OMAR = rd_ptr[ADDR_W-1:0];
    end
  end

  // Edge detectors, unload FSM, output word register and per-run statistics.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      fin_d1           <= 1'b0;
      fin_d2           <= 1'b0;
      neg_d1           <= 1'b0;
      neg_d2           <= 1'b0;
      rd_ptr           <= '0;
      last_idx         <= '0;
      strm.out_valid   <= 1'b0;
      strm.out_data    <= '0;
      strm.out_last    <= 1'b0;
      strm.out_unreach <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      neg_flag         <= 1'b0;
      unreach_cnt      <= '0;
      max_dist         <= '0;
`ifdef OUTPUT_UNLOADER_CHECKSUM_EN
      cks              <= '0;
      cks_pend         <= 1'b0;
`endif
    end else begin
      fin_d1 <= Finish;
      fin_d2 <= fin_d1;
      neg_d1 <= NegCycle;
      neg_d2 <= neg_d1;
      done   <= 1'b0;

      case (state)
        IDLE: begin
          if (neg_rise) begin
            state    <= NEG;
            busy     <= 1'b1;
            neg_flag <= 1'b1;
          end else if (fin_rise) begin
            state       <= STREAM;
            busy        <= 1'b1;
            last_idx    <= n_last;
            rd_ptr      <= '0;
            unreach_cnt <= '0;
            max_dist    <= '0;
`ifdef OUTPUT_UNLOADER_CHECKSUM_EN
            cks         <= '0;
            cks_pend    <= 1'b0;
`endif
          end
        end

        STREAM: begin
          if (neg_rise) begin
            strm.out_valid <= 1'b0;
            state          <= NEG;
            neg_flag       <= 1'b1;
          end else if (load) begin
            strm.out_valid   <= 1'b1;
            strm.out_data    <= OMDR;
            strm.out_unreach <= word_unreach;
`ifdef OUTPUT_UNLOADER_CHECKSUM_EN
            // The final flag belongs to the trailing checksum word, never a distance word.
            strm.out_last    <= 1'b0;
            cks              <= cks + OMDR;
            cks_pend         <= at_last;
`else
            strm.out_last    <= at_last;
`endif
            if (word_unreach) begin
              unreach_cnt <= unreach_cnt + PTR_ONE;
            end else if (OMDR > max_dist) begin
              max_dist <= OMDR;
            end
            rd_ptr <= rd_ptr + PTR_ONE;
            if (at_last) begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (neg_rise) begin
            strm.out_valid <= 1'b0;
            state          <= NEG;
            neg_flag       <= 1'b1;
`ifdef OUTPUT_UNLOADER_CHECKSUM_EN
            cks_pend       <= 1'b0;
          end else if (cks_pend) begin
            // Last distance word still occupies the register; swap in the sum once it is taken.
            if (strm.out_ready) begin
              strm.out_data    <= cks;
              strm.out_unreach <= 1'b0;
              strm.out_last    <= 1'b1;
              cks_pend         <= 1'b0;
            end
`endif
          end else if (strm.out_valid && strm.out_ready) begin
            strm.out_valid <= 1'b0;
            strm.out_last  <= 1'b0;
            done           <= 1'b1;
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end

        NEG: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_unloader.sv
// tb_output_unloader: scoreboard bench for output_unloader. Expected words are
// computed from the memory image when a run is started and compared on handshakes.
module tb_output_unloader;
  localparam int AW = 13;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          Finish = 1'b0;
  logic          NegCycle = 1'b0;
  logic [AW:0]   num_nodes = '0;
  logic [AW-1:0] OMAR;
  logic [DW-1:0] OMDR;
  logic          busy, done, neg_flag;
  logic [AW:0]   unreach_cnt;
  logic [DW-1:0] max_dist;
  logic [DW-1:0] mem [0:8191];

  output_unloader_if #(.DATA_W(DW)) strm ();

  output_unloader #(.ADDR_W(AW), .DATA_W(DW), .UNREACH(16'hFFFF)) dut (
    .clock       (clock),
    .reset       (reset),
    .Finish      (Finish),
    .NegCycle    (NegCycle),
    .num_nodes   (num_nodes),
    .OMAR        (OMAR),
    .OMDR        (OMDR),
    .strm        (strm),
    .busy        (busy),
    .done        (done),
    .neg_flag    (neg_flag),
    .unreach_cnt (unreach_cnt),
    .max_dist    (max_dist)
  );

  assign OMDR = mem[OMAR];
  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
    logic        u;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          exp_ucnt;
  logic [15:0] exp_max;

  function automatic int eff_nodes(input int n);
    if (n == 0) return 1;
    if (n > 8192) return 8192;
    return n;
  endfunction

  // Reference model: expected stream and summary counts from the memory image.
  task automatic push_expected(input int n);
    int          e;
    logic [15:0] sum;
    exp_t        x;
    e = eff_nodes(n);
    sum = '0;
    sb.delete();
    exp_ucnt = 0;
    exp_max = '0;
    for (int i = 0; i < e; i++) begin
      x.d = mem[i];
      x.u = (mem[i] == 16'hFFFF);
      sum = sum + mem[i];
      if (x.u) exp_ucnt++;
      else if (mem[i] > exp_max) exp_max = mem[i];
`ifdef OUTPUT_UNLOADER_CHECKSUM_EN
      x.l = 1'b0;
`else
      x.l = (i == e - 1);
`endif
      sb.push_back(x);
    end
`ifdef OUTPUT_UNLOADER_CHECKSUM_EN
    x.d = sum;
    x.l = 1'b1;
    x.u = 1'b0;
    sb.push_back(x);
`endif
  endtask

  task automatic start_run(input int n);
    Finish = 1'b0;
    strm.out_ready = 1'b0;
    num_nodes = n[AW:0];
    repeat (3) @(negedge clock);
    push_expected(n);
    Finish = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({strm.out_valid, strm.out_last, strm.out_unreach, busy, done, neg_flag} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {strm.out_valid, strm.out_last, strm.out_unreach, busy, done, neg_flag});
    end
    checks++;
    if (strm.out_data !== 16'h0 || OMAR !== '0) begin
      errors++;
      $display("FAIL reset_data_addr: got data=%h omar=%0d want 0/0", strm.out_data, OMAR);
    end
    checks++;
    if (unreach_cnt !== '0 || max_dist !== '0) begin
      errors++;
      $display("FAIL reset_stats: got ucnt=%0d max=%h want 0/0", unreach_cnt, max_dist);
    end
    #3 reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (strm.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got valid=%b busy=%b want 0/0", strm.out_valid, busy);
    end
  endtask

  // mode 0: ready held high, 1: ready 1,0,0 repeating, 2: random ready.
  task automatic test_stream(input string name, input int n, input int mode);
    int          eff, lat, cyc, hs, budget, words, omar_max;
    logic        r, stalled, fin;
    exp_t        cur, held, e;
    eff = eff_nodes(n);
    start_run(n);
    words = sb.size();
    budget = (mode == 0) ? words + 10 : words * 8 + 50;
    lat = 0;
    while (!strm.out_valid && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL %s first_valid_latency: got %0d want 3", name, lat);
    end
    cyc = 0; hs = 0; stalled = 1'b0; fin = 1'b0; omar_max = 0; held = '0;
    while (!fin && cyc < budget) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      strm.out_ready = r;
      #1;
      if (int'(OMAR) > omar_max) omar_max = int'(OMAR);
      cur = {strm.out_data, strm.out_last, strm.out_unreach};
      if (stalled) begin
        checks++;
        if (strm.out_valid !== 1'b1 || cur !== held) begin
          errors++;
          $display("FAIL %s stall_hold: got v=%b %h want v=1 %h", name, strm.out_valid, cur, held);
        end
      end
      stalled = 1'b0;
      if (strm.out_valid && r) begin
        checks++;
        hs++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s extra_word: got %h want none", name, cur);
        end else begin
          e = sb.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL %s word%0d: got data=%h last=%b unr=%b want data=%h last=%b unr=%b",
                     name, hs - 1, cur.d, cur.l, cur.u, e.d, e.l, e.u);
          end
          if (e.l) fin = 1'b1;
        end
      end else if (strm.out_valid) begin
        stalled = 1'b1;
        held = cur;
      end
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (!fin || sb.size() != 0) begin
      errors++;
      $display("FAIL %s stream_complete: got fin=%b left=%0d want fin=1 left=0", name, fin, sb.size());
    end
    if (mode == 0) begin
      checks++;
      if (hs !== words || cyc !== words) begin
        errors++;
        $display("FAIL %s throughput: got hs=%0d cycles=%0d want %0d/%0d", name, hs, cyc, words, words);
      end
    end
    checks++;
    if (omar_max !== eff - 1) begin
      errors++;
      $display("FAIL %s last_addr: got %0d want %0d", name, omar_max, eff - 1);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || strm.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: got done=%b busy=%b valid=%b want 1/0/0", name, done, busy, strm.out_valid);
    end
    checks++;
    if (unreach_cnt !== exp_ucnt[AW:0] || max_dist !== exp_max) begin
      errors++;
      $display("FAIL %s stats: got ucnt=%0d max=%h want %0d/%h", name, unreach_cnt, max_dist, exp_ucnt, exp_max);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_width: got %b want 0", name, done);
    end
    Finish = 1'b0;
    strm.out_ready = 1'b0;
  endtask

  task automatic test_finish_busy();
    int   wait_c, words, tail;
    exp_t e, cur;
    mem[0] = 16'd100; mem[1] = 16'd200; mem[2] = 16'd300; mem[3] = 16'd400;
    start_run(4);
    wait_c = 0;
    while (!strm.out_valid && wait_c < 10) begin
      @(negedge clock);
      wait_c++;
    end
    Finish = 1'b0;
    repeat (2) @(negedge clock);
    Finish = 1'b1;
    repeat (2) @(negedge clock);
    strm.out_ready = 1'b1;
    words = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (strm.out_valid) begin
        cur = {strm.out_data, strm.out_last, strm.out_unreach};
        words++;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checks++;
          if (cur !== e) begin
            errors++;
            $display("FAIL finish_busy word: got %h want %h", cur, e);
          end
        end
      end
      @(negedge clock);
    end
    tail = 0;
    repeat (8) begin
      @(negedge clock);
      if (strm.out_valid) tail++;
    end
    checks++;
    if (words !== 4 || tail !== 0) begin
      errors++;
      $display("FAIL finish_busy count: got words=%0d restart=%0d want 4/0", words, tail);
    end
    Finish = 1'b0;
    strm.out_ready = 1'b0;
  endtask

  task automatic test_neg_idle();
    int dp, vs;
    Finish = 1'b0;
    strm.out_ready = 1'b1;
    @(negedge clock);
    NegCycle = 1'b1;
    dp = 0; vs = 0;
    repeat (8) begin
      @(negedge clock);
      if (done) dp++;
      if (strm.out_valid) vs++;
    end
    checks++;
    if (dp !== 1 || vs !== 0) begin
      errors++;
      $display("FAIL neg_idle pulses: got done=%0d valid=%0d want 1/0", dp, vs);
    end
    checks++;
    if (neg_flag !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL neg_idle flag: got neg=%b busy=%b want 1/0", neg_flag, busy);
    end
    NegCycle = 1'b0;
    strm.out_ready = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_neg_mid();
    int   hs, cyc, lat, extra, dp;
    exp_t e, cur;
    mem[0] = 16'd10; mem[1] = 16'd20; mem[2] = 16'd30; mem[3] = 16'd40;
    start_run(4);
    strm.out_ready = 1'b1;
    hs = 0; cyc = 0;
    while (hs < 2 && cyc < 20) begin
      @(negedge clock);
      cyc++;
      if (strm.out_valid) begin
        cur = {strm.out_data, strm.out_last, strm.out_unreach};
        e = sb.pop_front();
        hs++;
        checks++;
        if (cur !== e) begin
          errors++;
          $display("FAIL neg_mid word%0d: got %h want %h", hs - 1, cur, e);
        end
      end
    end
    @(negedge clock);
    strm.out_ready = 1'b0;
    NegCycle = 1'b1;
    lat = 0; extra = 0; dp = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (done) dp++;
      if (lat == 0 && !strm.out_valid) begin
        lat = k;
        strm.out_ready = 1'b1;
      end else if (lat != 0 && strm.out_valid) begin
        extra++;
      end
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL neg_mid drop_latency: got %0d want 2", lat);
    end
    checks++;
    if (extra !== 0 || dp !== 1) begin
      errors++;
      $display("FAIL neg_mid after_abort: got words=%0d done=%0d want 0/1", extra, dp);
    end
    checks++;
    if (neg_flag !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL neg_mid flag: got neg=%b busy=%b want 1/0", neg_flag, busy);
    end
    sb.delete();
    NegCycle = 1'b0;
    Finish = 1'b0;
    strm.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    int vs, wait_c;
    mem[0] = 16'd7; mem[1] = 16'd8; mem[2] = 16'd9; mem[3] = 16'd11;
    start_run(4);
    strm.out_ready = 1'b1;
    wait_c = 0;
    while (!strm.out_valid && wait_c < 10) begin
      @(negedge clock);
      wait_c++;
    end
    @(negedge clock);
    #2 reset = 1'b1;
    Finish = 1'b0;
    #1;
    checks++;
    if ({strm.out_valid, strm.out_last, strm.out_unreach, busy, done, neg_flag} !== 6'b0 ||
        strm.out_data !== 16'h0 || OMAR !== '0 || unreach_cnt !== '0 || max_dist !== '0) begin
      errors++;
      $display("FAIL async_reset outputs: got v=%b busy=%b neg=%b data=%h omar=%0d ucnt=%0d max=%h want all 0",
               strm.out_valid, busy, neg_flag, strm.out_data, OMAR, unreach_cnt, max_dist);
    end
    @(negedge clock);
    reset = 1'b0;
    vs = 0;
    repeat (10) begin
      @(negedge clock);
      if (strm.out_valid || busy) vs++;
    end
    checks++;
    if (vs !== 0) begin
      errors++;
      $display("FAIL async_reset resume: got %0d active cycles want 0", vs);
    end
  endtask

  initial begin
    strm.out_ready = 1'b0;
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0;

    test_reset();

    mem[0] = 16'h0000; mem[1] = 16'h0005; mem[2] = 16'hFFFF; mem[3] = 16'h000C;
    test_stream("basic", 4, 0);
    test_stream("backpressure", 4, 1);

    for (int i = 0; i < 8; i++) mem[i] = (i == 5) ? 16'hFFFF : 16'($urandom_range(0, 65534));
    test_stream("random_ready", 8, 2);

    mem[0] = 16'h0007;
    test_stream("zero_nodes", 0, 0);

`ifdef OUTPUT_UNLOADER_CHECKSUM_EN
    mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3;
    test_stream("checksum", 3, 0);
`endif

    for (int i = 0; i < 8192; i++) mem[i] = 16'hFFFF;
    test_stream("max_nodes", 8192, 0);

    test_finish_busy();
    test_neg_idle();
    test_neg_mid();
    test_async_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
